// File: rtl/gen_gray_pkg.sv
// ---------------------------------------------------------------------------
// gen_gray_pkg
// Shared constants and conversion helpers for the Gray/binary codec pipe.
//   MODE_G2B / MODE_B2G : transaction direction encoding (in_mode/out_mode)
//   gray2bin            : Gray -> binary, prefix XOR from the MSB down
//   bin2gray            : binary -> Gray, b ^ (b >> 1)
//   multi_bit_step      : 1 when x has two or more bits set
// The helpers work on a fixed-width container word and take the live width
// as an argument; callers zero-extend into the container and truncate the
// result back to their own WIDTH.
// ---------------------------------------------------------------------------
package gen_gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Widest lane the helpers support.
    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Ones in bit positions [width-1:0].
    function automatic gray_word_t width_mask(input int width);
        gray_word_t m;
        m = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            m[i] = (i < width);
        end
        return m;
    endfunction

    function automatic gray_word_t bin2gray(input gray_word_t b, input int width);
        gray_word_t bm;
        bm = b & width_mask(width);
        return bm ^ (bm >> 1);
    endfunction

    // b[i] is the running parity of g[width-1:i].
    function automatic gray_word_t gray2bin(input gray_word_t g, input int width);
        gray_word_t b;
        logic       p;
        b = '0;
        p = 1'b0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            if (i < width) begin
                p    = p ^ g[i];
                b[i] = p;
            end
        end
        return b;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_bit_step(input gray_word_t x, input int width);
        gray_word_t xm;
        xm = x & width_mask(width);
        return (xm & (xm - gray_word_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/gen_gray_codec_lane.sv
// ---------------------------------------------------------------------------
// gen_gray_codec_lane
// One lane of the codec: Gray history register, step check and conversion.
//   clk, rst      : clock, synchronous active-high reset
//   acc           : a beat is accepted this cycle
//   chk_mode      : mode of the incoming beat (history / step check side)
//   chk_data      : lane value of the incoming beat
//   conv_mode     : mode of the value being converted
//   conv_data     : lane value being converted (raw input or stage-1 copy)
//   step_err      : incoming G2B value differs from history in >1 bit
//   conv_out      : converted value of conv_data
// The step check reads the history as it stands before this beat's update,
// so back-to-back accepted beats are each checked against their predecessor.
// ---------------------------------------------------------------------------
module gen_gray_codec_lane
    import gen_gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc,
    input  logic             chk_mode,
    input  logic [WIDTH-1:0] chk_data,
    input  logic             conv_mode,
    input  logic [WIDTH-1:0] conv_data,
    output logic             step_err,
    output logic [WIDTH-1:0] conv_out
);

    logic [WIDTH-1:0] hist_d, hist_q;
    logic             hist_v_d, hist_v_q;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        hist_d   = hist_q;
        hist_v_d = hist_v_q;
        // Only accepted G2B beats move the history; B2G beats pass through it.
        if (acc && chk_mode == MODE_G2B) begin
            hist_d   = chk_data;
            hist_v_d = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q   <= '0;
            hist_v_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            hist_v_q <= hist_v_d;
        end
    end

    always_comb begin
        step_err = 1'b0;
        if (chk_mode == MODE_G2B && hist_v_q) begin
            step_err = multi_bit_step(gray_word_t'(chk_data ^ hist_q), WIDTH);
        end
    end

    always_comb begin
        conv_out = WIDTH'(gray2bin(gray_word_t'(conv_data), WIDTH));
        if (conv_mode == MODE_B2G) begin
            conv_out = WIDTH'(bin2gray(gray_word_t'(conv_data), WIDTH));
        end
    end

endmodule

// File: rtl/gen_gray_codec_pipe.sv
// ---------------------------------------------------------------------------
// gen_gray_codec_pipe
// Pipelined multi-channel Gray/binary converter with valid/ready handshake.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_mode               : 0 = Gray->binary, 1 = binary->Gray
//   in_data               : CHANNELS lanes of WIDTH bits, lane k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready   : output handshake
//   out_mode, out_data    : mode and converted lanes of the presented beat
//   out_err               : per-lane Gray step error of the presented beat
//   err_sticky, err_clr   : per-lane OR of delivered errors, and its clear
// PIPE = 1 registers conversion, mode and error in a single stage.
// PIPE = 2 registers raw data and error in stage 1, conversion in stage 2.
// The only combinational input-to-output path is out_ready -> in_ready.
// ---------------------------------------------------------------------------
module gen_gray_codec_pipe
    import gen_gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int PIPE     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_mode,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_err,
    output logic [CHANNELS-1:0]       err_sticky,
    input  logic                      err_clr
);

    localparam int DW = CHANNELS * WIDTH;

    logic                in_ready_raw;
    logic                accept;
    logic                conv_mode;
    logic [DW-1:0]       conv_src;
    logic [DW-1:0]       conv_res;
    logic [CHANNELS-1:0] step_err;

    logic                last_v;
    logic                last_mode;
    logic [DW-1:0]       last_data;
    logic [CHANNELS-1:0] last_err;

    logic [CHANNELS-1:0] err_sticky_d, err_sticky_q;

    // Held low during reset; otherwise purely a function of stage state and out_ready.
    assign in_ready = in_ready_raw & ~rst;
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        gen_gray_codec_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .acc       (accept),
            .chk_mode  (in_mode),
            .chk_data  (in_data[k*WIDTH +: WIDTH]),
            .conv_mode (conv_mode),
            .conv_data (conv_src[k*WIDTH +: WIDTH]),
            .step_err  (step_err[k]),
            .conv_out  (conv_res[k*WIDTH +: WIDTH])
        );
    end

    if (PIPE == 1) begin : g_pipe1

        logic                s1_v_d, s1_v_q;
        logic                s1_mode_d, s1_mode_q;
        logic [DW-1:0]       s1_data_d, s1_data_q;
        logic [CHANNELS-1:0] s1_err_d, s1_err_q;

        assign conv_src     = in_data;
        assign conv_mode    = in_mode;
        assign in_ready_raw = ~s1_v_q | out_ready;

        always_comb begin
            s1_v_d    = s1_v_q;
            s1_mode_d = s1_mode_q;
            s1_data_d = s1_data_q;
            s1_err_d  = s1_err_q;
            // Stage is empty or draining: it takes whatever is offered.
            if (in_ready_raw) begin
                s1_v_d = in_valid;
            end
            if (accept) begin
                s1_mode_d = in_mode;
                s1_data_d = conv_res;
                s1_err_d  = step_err;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_v_q    <= 1'b0;
                s1_mode_q <= 1'b0;
                s1_data_q <= '0;
                s1_err_q  <= '0;
            end else begin
                s1_v_q    <= s1_v_d;
                s1_mode_q <= s1_mode_d;
                s1_data_q <= s1_data_d;
                s1_err_q  <= s1_err_d;
            end
        end

        assign last_v    = s1_v_q;
        assign last_mode = s1_mode_q;
        assign last_data = s1_data_q;
        assign last_err  = s1_err_q;

    end else begin : g_pipe2

        logic                s1_v_d, s1_v_q;
        logic                s1_mode_d, s1_mode_q;
        logic [DW-1:0]       s1_data_d, s1_data_q;
        logic [CHANNELS-1:0] s1_err_d, s1_err_q;
        logic                s2_v_d, s2_v_q;
        logic                s2_mode_d, s2_mode_q;
        logic [DW-1:0]       s2_data_d, s2_data_q;
        logic [CHANNELS-1:0] s2_err_d, s2_err_q;
        logic                s2_open;
        logic                ld2;

        // Stage 2 can take a beat when empty or when its own beat leaves now.
        assign s2_open      = ~s2_v_q | out_ready;
        assign ld2          = s1_v_q & s2_open;
        assign in_ready_raw = ~s1_v_q | ~s2_v_q | out_ready;
        assign conv_src     = s1_data_q;
        assign conv_mode    = s1_mode_q;

        always_comb begin
            s1_v_d    = s1_v_q;
            s1_mode_d = s1_mode_q;
            s1_data_d = s1_data_q;
            s1_err_d  = s1_err_q;
            s2_v_d    = s2_v_q;
            s2_mode_d = s2_mode_q;
            s2_data_d = s2_data_q;
            s2_err_d  = s2_err_q;

            if (in_ready_raw) begin
                s1_v_d = in_valid;
            end
            // Error is resolved at accept time, against pre-update history.
            if (accept) begin
                s1_mode_d = in_mode;
                s1_data_d = in_data;
                s1_err_d  = step_err;
            end

            if (s2_open) begin
                s2_v_d = s1_v_q;
            end
            if (ld2) begin
                s2_mode_d = s1_mode_q;
                s2_data_d = conv_res;
                s2_err_d  = s1_err_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_v_q    <= 1'b0;
                s1_mode_q <= 1'b0;
                s1_data_q <= '0;
                s1_err_q  <= '0;
                s2_v_q    <= 1'b0;
                s2_mode_q <= 1'b0;
                s2_data_q <= '0;
                s2_err_q  <= '0;
            end else begin
                s1_v_q    <= s1_v_d;
                s1_mode_q <= s1_mode_d;
                s1_data_q <= s1_data_d;
                s1_err_q  <= s1_err_d;
                s2_v_q    <= s2_v_d;
                s2_mode_q <= s2_mode_d;
                s2_data_q <= s2_data_d;
                s2_err_q  <= s2_err_d;
            end
        end

        assign last_v    = s2_v_q;
        assign last_mode = s2_mode_q;
        assign last_data = s2_data_q;
        assign last_err  = s2_err_q;

    end

    assign out_valid = last_v;
    assign out_mode  = last_mode;
    assign out_data  = last_data;
    assign out_err   = last_err;

    // A delivered error beats a simultaneous clear.
    always_comb begin
        err_sticky_d = err_sticky_q;
        if (err_clr) begin
            err_sticky_d = '0;
        end
        if (out_valid && out_ready) begin
            err_sticky_d = err_sticky_d | out_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_gen_gray_codec_pipe.sv
// ---------------------------------------------------------------------------
// tb_gen_gray_codec_pipe
// Directed stimulus against gen_gray_codec_pipe (WIDTH=4, CHANNELS=2, PIPE=2).
// A behavioural model predicts every delivered beat and err_sticky; a monitor
// compares on each falling edge. Literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_gen_gray_codec_pipe;

    localparam int W  = 4;
    localparam int C  = 2;
    localparam int P  = 2;
    localparam int DW = W * C;
    localparam logic G2B = 1'b0;
    localparam logic B2G = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_mode;
    logic [DW-1:0] out_data;
    logic [C-1:0]  out_err;
    logic [C-1:0]  err_sticky;
    logic          err_clr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          mode;
        logic [C-1:0]  err;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        got_q[$];
    logic [W-1:0] m_hist [C];
    logic [C-1:0] m_hist_v;
    logic [C-1:0] m_sticky;
    bit           mon_en = 1'b0;

    always #5 clk = ~clk;

    gen_gray_codec_pipe #(
        .WIDTH    (W),
        .CHANNELS (C),
        .PIPE     (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mode   (out_mode),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inverse by search: the binary value whose Gray code is g.
    function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
        logic [W-1:0] bb;
        for (int b = 0; b < (1 << W); b++) begin
            bb = W'(b);
            if (m_b2g(bb) == g) return bb;
        end
        return '0;
    endfunction

    always @(negedge clk) begin
        beat_t        nb;
        beat_t        hd;
        logic [C-1:0] sticky_nxt;
        logic [W-1:0] v;
        if (mon_en) begin
            check("err_sticky", err_sticky, m_sticky);
            if (rst) begin
                exp_q.delete();
                m_hist_v = '0;
                for (int k = 0; k < C; k++) m_hist[k] = '0;
                m_sticky = '0;
            end else begin
                sticky_nxt = err_clr ? '0 : m_sticky;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("out_valid_without_beat", out_valid, 1'b0);
                    end else begin
                        hd = exp_q[0];
                        check("out_data", out_data, hd.data);
                        check("out_mode", out_mode, hd.mode);
                        check("out_err", out_err, hd.err);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            got_q.push_back(hd);
                            sticky_nxt = sticky_nxt | hd.err;
                        end
                    end
                end
                m_sticky = sticky_nxt;
                if (in_valid && in_ready) begin
                    nb.mode = in_mode;
                    nb.data = '0;
                    nb.err  = '0;
                    for (int k = 0; k < C; k++) begin
                        v = in_data[k*W +: W];
                        if (in_mode == B2G) begin
                            nb.data[k*W +: W] = m_b2g(v);
                        end else begin
                            nb.data[k*W +: W] = m_g2b(v);
                            nb.err[k]  = m_hist_v[k] && ($countones(v ^ m_hist[k]) > 1);
                            m_hist[k]  = v;
                            m_hist_v[k] = 1'b1;
                        end
                    end
                    exp_q.push_back(nb);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic mode, input logic [DW-1:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                timeout("send");
                break;
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) break;
            n++;
            if (n > 50) begin
                timeout("drain");
                break;
            end
        end
        step();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
    endtask

    task automatic expect_beat(input string name, input int idx, input logic [DW-1:0] d,
                               input logic m, input logic [C-1:0] e);
        check({name, "_data"}, got_q[idx].data, d);
        check({name, "_mode"}, got_q[idx].mode, m);
        check({name, "_err"}, got_q[idx].err, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           base;
        int           cyc;
        logic         acc;
        logic [3:0]   vv;
        logic [3:0]   gtab [8];
        gtab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = G2B;
        in_data   = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;

        // ---- reset state ----
        step();
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_err", out_err, '0);
        check("rst_out_mode", out_mode, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        step();

        // ---- basic conversion and latency ----
        base = got_q.size();
        send(G2B, {4'b0000, 4'b1101});
        @(negedge clk);
        check("lat_cycle1_idle", out_valid, 1'b0);
        @(negedge clk);
        check("lat_cycle2_valid", out_valid, 1'b1);
        check("lat_cycle2_lane0", out_data[3:0], 4'b1001);
        drain();
        send(B2G, {4'b0110, 4'b1001});
        drain();
        expect_beat("basic_g2b", base, {4'b0000, 4'b1001}, G2B, 2'b00);
        expect_beat("basic_b2g", base + 1, {4'b0101, 4'b1101}, B2G, 2'b00);

        // ---- step check and sticky clear ----
        do_reset();
        base = got_q.size();
        send(G2B, {4'b0000, 4'b0000});
        send(G2B, {4'b0000, 4'b0011});
        send(G2B, {4'b0000, 4'b0010});
        drain();
        expect_beat("step0", base, {4'b0000, 4'b0000}, G2B, 2'b00);
        expect_beat("step1", base + 1, {4'b0000, 4'b0010}, G2B, 2'b01);
        expect_beat("step2", base + 2, {4'b0000, 4'b0011}, G2B, 2'b00);
        @(negedge clk);
        check("step_sticky_set", err_sticky, 2'b01);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        check("step_sticky_cleared", err_sticky, 2'b00);
        step();

        // ---- history isolation ----
        do_reset();
        base = got_q.size();
        send(G2B, {4'b0000, 4'b0001});
        send(B2G, {4'b0000, 4'b1111});
        send(G2B, {4'b0000, 4'b0011});
        drain();
        expect_beat("iso0", base, {4'b0000, 4'b0001}, G2B, 2'b00);
        expect_beat("iso1", base + 1, {4'b0000, 4'b1000}, B2G, 2'b00);
        expect_beat("iso2", base + 2, {4'b0000, 4'b0010}, G2B, 2'b00);

        // ---- backpressure ----
        do_reset();
        base      = got_q.size();
        vv        = 4'd0;
        cyc       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = B2G;
        in_data   = {vv, vv};
        while (vv < 4'd8 && cyc < 60) begin
            @(negedge clk);
            if (cyc == 1) check("bp_in_ready_one_held", in_ready, 1'b1);
            if (cyc == 2) begin
                check("bp_in_ready_two_held", in_ready, 1'b0);
                check("bp_out_valid_stalled", out_valid, 1'b1);
            end
            acc = in_ready;
            step();
            cyc++;
            if (acc) begin
                vv      = vv + 4'd1;
                in_data = {vv, vv};
            end
            if (cyc == 3) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", vv, 4'd8);
        drain();
        check("bp_delivered_count", got_q.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            expect_beat($sformatf("bp_beat%0d", i), base + i, {gtab[i], gtab[i]}, B2G, 2'b00);
        end

        // ---- reset mid-operation ----
        do_reset();
        send(G2B, {4'b0000, 4'b0000});
        send(G2B, {4'b0000, 4'b0011});
        drain();
        @(negedge clk);
        check("midrst_sticky_before", err_sticky, 2'b01);
        step();
        out_ready = 1'b0;
        send(G2B, {4'b0000, 4'b0001});
        send(G2B, {4'b0000, 4'b0000});
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sticky", err_sticky, 2'b00);
        step();
        base = got_q.size();
        send(G2B, {4'b0000, 4'b1111});
        drain();
        check("midrst_delivered_count", got_q.size() - base, 1);
        expect_beat("midrst_first", base, {4'b0000, 4'b1010}, G2B, 2'b00);

        // ---- sticky set and clear in the same cycle ----
        do_reset();
        send(G2B, {4'b0000, 4'b0000});
        drain();
        out_ready = 1'b0;
        send(G2B, {4'b0000, 4'b0011});
        @(negedge clk);
        check("setclr_not_yet_valid", out_valid, 1'b0);
        step();
        @(negedge clk);
        check("setclr_valid", out_valid, 1'b1);
        check("setclr_err", out_err, 2'b01);
        check("setclr_sticky_before", err_sticky, 2'b00);
        step();
        out_ready = 1'b1;
        err_clr   = 1'b1;
        step();
        err_clr   = 1'b0;
        @(negedge clk);
        check("setclr_set_wins", err_sticky, 2'b01);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
